qspi_sclk_gen: RTL and testbench

Clock/timing generator for the QSPI transmit path. It produces SCLK, chip-select and the one-cycle shift_en_out / sample_en_out strobes. These strobes drive the QSPI multi-lane output shift register and the receive sampler. Per transfer it converts a bit count plus lane mode (1/2/4 IO lines) into a beat count, and sequences CS setup, clocking and CS hold.

---
 rtl/qspi_sclk_gen_if.sv | 44 ++++
 rtl/qspi_sclk_gen.sv | 176 +++++++++++++++++
 tb/tb_qspi_sclk_gen.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_sclk_gen_if.sv
// Control and timing signal bundle between the QSPI controller and qspi_sclk_gen.
// Optional abort_in is present only when QSPI_ABORT_EN is defined.
interface qspi_sclk_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
);
  logic             start_in;
  logic [DIV_W-1:0] clk_div_in;
  logic             cpol_in;
  logic [CNT_W-1:0] num_bits_in;
  logic             use_1_io_lines_in;
  logic             use_2_io_lines_in;
  logic             use_4_io_lines_in;
`ifdef QSPI_ABORT_EN
  logic             abort_in;
`endif
  logic             sclk_out;
  logic             cs_n_out;
  logic             shift_en_out;
  logic             sample_en_out;
  logic             busy_out;
  logic             done_out;

  // Handshake: start_in is a level sampled on any clk edge where the generator
  // is idle; busy_out stays high until the cycle done_out pulses, after which
  // a new start_in (even in the done cycle) is accepted.
  modport master (
`ifdef QSPI_ABORT_EN
    output abort_in,
`endif
    output start_in, clk_div_in, cpol_in, num_bits_in,
    output use_1_io_lines_in, use_2_io_lines_in, use_4_io_lines_in,
    input  sclk_out, cs_n_out, shift_en_out, sample_en_out, busy_out, done_out
  );

  modport slave (
`ifdef QSPI_ABORT_EN
    input  abort_in,
`endif
    input  start_in, clk_div_in, cpol_in, num_bits_in,
    input  use_1_io_lines_in, use_2_io_lines_in, use_4_io_lines_in,
    output sclk_out, cs_n_out, shift_en_out, sample_en_out, busy_out, done_out
  );
endinterface

// File: rtl/qspi_sclk_gen.sv
// QSPI SCLK / chip-select / shift-sample strobe sequencer (IDLE-SETUP-RUN-HOLD).
// Define QSPI_ABORT_EN to add bus.abort_in, which cuts a transfer short into HOLD.
module qspi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  qspi_sclk_gen_if.slave       bus,
  output logic [1:0]           state_dbg_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] dval_q, dval_d;
  logic             cpol_q, cpol_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tick;
  logic             abort_req;
  logic [CNT_W:0]   nb_ext;
  logic [CNT_W-1:0] beats_calc;

`ifdef QSPI_ABORT_EN
  assign abort_req = bus.abort_in;
`else
  assign abort_req = 1'b0;
`endif

  assign tick = (div_q == dval_q);

  // Beats per transfer: lane priority 4 > 2 > 1, no mode selected means one lane.
  always_comb begin
    nb_ext     = {1'b0, bus.num_bits_in};
    beats_calc = bus.num_bits_in;
    if (bus.use_4_io_lines_in)
      beats_calc = CNT_W'((nb_ext + (CNT_W+1)'(3)) >> 2);
    else if (bus.use_2_io_lines_in)
      beats_calc = CNT_W'((nb_ext + (CNT_W+1)'(1)) >> 1);
    else if (bus.use_1_io_lines_in)
      beats_calc = bus.num_bits_in;
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    dval_d     = dval_q;
    cpol_d     = cpol_q;
    phase_d    = phase_q;
    beat_cnt_d = beat_cnt_q;
    sclk_d     = cpol_q;
    cs_n_d     = cs_n_q;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE)
      div_d = tick ? '0 : div_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        div_d  = '0;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (bus.start_in) begin
          dval_d     = bus.clk_div_in;
          cpol_d     = bus.cpol_in;
          sclk_d     = bus.cpol_in;
          beat_cnt_d = beats_calc;
          if (bus.num_bits_in != '0) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (abort_req) begin
          state_d = HOLD;
          div_d   = '0;
        end else if (tick) begin
          state_d = RUN;
          phase_d = 1'b0;
        end
      end
      RUN: begin
        sclk_d = sclk_q;
        if (abort_req) begin
          state_d = HOLD;
          div_d   = '0;
          sclk_d  = cpol_q;
        end else if (tick) begin
          if (!phase_q) begin
            sclk_d   = ~cpol_q;
            sample_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            sclk_d     = cpol_q;
            beat_cnt_d = beat_cnt_q - CNT_W'(1);
            phase_d    = 1'b0;
            // The final trailing edge has no next bit to shift out.
            if (beat_cnt_q == CNT_W'(1))
              state_d = HOLD;
            else
              shift_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      dval_q     <= '0;
      cpol_q     <= 1'b0;
      phase_q    <= 1'b0;
      beat_cnt_q <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      shift_q    <= 1'b0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      dval_q     <= dval_d;
      cpol_q     <= cpol_d;
      phase_q    <= phase_d;
      beat_cnt_q <= beat_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sclk_out      = sclk_q;
  assign bus.cs_n_out      = cs_n_q;
  assign bus.shift_en_out  = shift_q;
  assign bus.sample_en_out = sample_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign state_dbg_out     = state_q;

endmodule

// File: tb/tb_qspi_sclk_gen.sv
// Bench for qspi_sclk_gen: directed and random transfers, per-transfer scoreboard
// of cs_n length, SCLK pulses and strobe counts, popped on every done_out.
module tb_qspi_sclk_gen;
  localparam int DIV_W = 8;
  localparam int CNT_W = 6;
  localparam int EXP_W = 57;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  qspi_sclk_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  qspi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .state_dbg_out (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // record: {cpol, cs_low[15:0], samples[7:0], shifts[7:0], pulses[7:0], active[15:0]}
  logic [EXP_W-1:0] exp_q[$];

  int   cs_cnt, samp_cnt, shift_cnt, pulse_cnt, act_cnt;
  int   done_cnt = 0;
  int   viol_cnt = 0;
  logic prev_act, cur_act;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input int cp, input int cs, input int s,
                                            input int sh, input int p, input int a);
    return {cp[0], cs[15:0], s[7:0], sh[7:0], p[7:0], a[15:0]};
  endfunction

  task automatic clear_acc();
    cs_cnt = 0; samp_cnt = 0; shift_cnt = 0; pulse_cnt = 0; act_cnt = 0; prev_act = 1'b0;
  endtask

  initial clear_acc();

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      clear_acc();
    end else begin
      if (bus.shift_en_out && bus.sample_en_out) viol_cnt++;
      if ((bus.shift_en_out || bus.sample_en_out) && bus.cs_n_out) viol_cnt++;
      if (bus.busy_out !== !bus.cs_n_out) viol_cnt++;
      if (!bus.cs_n_out) begin
        cs_cnt++;
        cur_act = (exp_q.size() > 0) && (bus.sclk_out !== exp_q[0][56]);
        if (cur_act) act_cnt++;
        if (cur_act && !prev_act) pulse_cnt++;
        prev_act = cur_act;
      end else begin
        prev_act = 1'b0;
      end
      if (bus.sample_en_out) samp_cnt++;
      if (bus.shift_en_out) shift_cnt++;
      if (bus.done_out) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done_out=1 expected no transfer pending");
        end else begin
          e = exp_q.pop_front();
          check("cs_low_cycles", cs_cnt,    32'(e[55:40]));
          check("sample_pulses", samp_cnt,  32'(e[39:32]));
          check("shift_pulses",  shift_cnt, 32'(e[31:24]));
          check("sclk_pulses",   pulse_cnt, 32'(e[23:16]));
          check("sclk_active",   act_cnt,   32'(e[15:0]));
          check("sclk_idle",     32'(bus.sclk_out), 32'(e[56]));
          check("done_cs_n",     32'(bus.cs_n_out), 32'd1);
        end
        clear_acc();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input string name);
    int t = 0;
    while (done_cnt == base && t < 4000) begin step(); t++; end
    if (done_cnt == base) begin
      checks++;
      failures++;
      $display("FAIL %s: got no done_out expected done within 4000 cycles", name);
    end
  endtask

  task automatic wait_samples(input int n, input string name);
    int t = 0;
    while (samp_cnt < n && t < 4000) begin step(); t++; end
    if (samp_cnt < n) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d samples expected %0d", name, samp_cnt, n);
    end
  endtask

  task automatic drive_start(input int n, input int mode, input int d, input int cp);
    bus.start_in          = 1'b1;
    bus.num_bits_in       = CNT_W'(n);
    bus.clk_div_in        = DIV_W'(d);
    bus.cpol_in           = cp[0];
    bus.use_1_io_lines_in = mode[0];
    bus.use_2_io_lines_in = mode[1];
    bus.use_4_io_lines_in = mode[2];
  endtask

  task automatic scramble_inputs();
    bus.start_in          = 1'b0;
    bus.num_bits_in       = CNT_W'($urandom);
    bus.clk_div_in        = DIV_W'($urandom);
    bus.cpol_in           = 1'($urandom);
    bus.use_1_io_lines_in = 1'($urandom);
    bus.use_2_io_lines_in = 1'($urandom);
    bus.use_4_io_lines_in = 1'($urandom);
  endtask

  // Expected behaviour from first principles: consume lanes bits per beat.
  function automatic logic [EXP_W-1:0] model(input int n, input int mode, input int d, input int cp);
    int lanes, beats, rem;
    lanes = mode[2] ? 4 : (mode[1] ? 2 : 1);
    beats = 0;
    rem   = n;
    while (rem > 0) begin beats++; rem -= lanes; end
    if (beats == 0) return pack(cp, 0, 0, 0, 0, 0);
    return pack(cp, (d + 1) * (2 + 2 * beats), beats, beats - 1, beats, beats * (d + 1));
  endfunction

  task automatic run_xfer(input int n, input int mode, input int d, input int cp, input bit poke);
    int base;
    exp_q.push_back(model(n, mode, d, cp));
    base = done_cnt;
    drive_start(n, mode, d, cp);
    step();
    scramble_inputs();
    if (n == 0) begin
      check("zero_done_latency", 32'(bus.done_out), 32'd1);
      check("zero_cs_n",         32'(bus.cs_n_out), 32'd1);
    end else begin
      check("start_busy", 32'(bus.busy_out), 32'd1);
      check("start_cs_n", 32'(bus.cs_n_out), 32'd0);
      if (poke) begin
        repeat (2) step();
        drive_start($urandom_range(1, 63), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1));
        step();
        scramble_inputs();
      end
    end
    wait_done(base, "xfer_done");
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"},   32'(bus.sclk_out),      32'd0);
    check({tag, "_cs_n"},   32'(bus.cs_n_out),      32'd1);
    check({tag, "_shift"},  32'(bus.shift_en_out),  32'd0);
    check({tag, "_sample"}, 32'(bus.sample_en_out), 32'd0);
    check({tag, "_busy"},   32'(bus.busy_out),      32'd0);
    check({tag, "_done"},   32'(bus.done_out),      32'd0);
    check({tag, "_state"},  32'(state_dbg),         32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bus.start_in = 1'b0;
    bus.num_bits_in = '0;
    bus.clk_div_in = '0;
    bus.cpol_in = 1'b0;
    bus.use_1_io_lines_in = 1'b0;
    bus.use_2_io_lines_in = 1'b0;
    bus.use_4_io_lines_in = 1'b0;
`ifdef QSPI_ABORT_EN
    bus.abort_in = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    run_xfer(32, 3'b100, 0, 0, 1'b0);
    run_xfer(8,  3'b010, 1, 0, 1'b0);
    run_xfer(5,  3'b001, 3, 1, 1'b0);
    run_xfer(6,  3'b100, 0, 0, 1'b0);
    run_xfer(3,  3'b000, 1, 0, 1'b0);
    run_xfer(0,  3'b001, 2, 1, 1'b0);
    run_xfer(16, 3'b001, 1, 0, 1'b1);
    run_xfer(63, 3'b111, 2, 1, 1'b0);

    // Reset in the middle of beat 3: the pending transfer is dropped.
    exp_q.push_back(model(32, 3'b100, 1, 0));
    drive_start(32, 3'b100, 1, 0);
    step();
    scramble_inputs();
    wait_samples(3, "rst_wait_beat3");
    rst = 1'b1;
    exp_q.delete();
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    base = done_cnt;
    repeat (20) step();
    check("no_done_after_rst", 32'(done_cnt - base), 32'd0);

`ifdef QSPI_ABORT_EN
    // Abort after the second leading edge with D=0: SETUP 1 + RUN 4 + HOLD 1 cycles.
    exp_q.push_back(pack(0, 6, 2, 1, 2, 2));
    base = done_cnt;
    drive_start(32, 3'b100, 0, 0);
    step();
    scramble_inputs();
    wait_samples(2, "abort_wait_beat2");
    bus.abort_in = 1'b1;
    step();
    bus.abort_in = 1'b0;
    wait_done(base, "abort_done");
    step();
`endif

    for (int i = 0; i < 20; i++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
      run_xfer(n, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1),
               1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    check("strobe_invariant_violations", 32'(viol_cnt), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
